// File: rtl/sipo_deser.sv
// ----------------------------------------------------------------------------
// sipo_deser -- serial-in / parallel-out deserializer, MSB first.
//
// A frame is FRAME accepted bits (a bit is accepted on a rising C edge with
// EN=1 and R=0). The first accepted bit of a frame ends up in Q[WIDTH-1].
// When the last bit of a frame is accepted, the assembled word is copied to Q
// and VALID pulses for exactly one cycle. The next frame may start in that
// same VALID cycle, so back-to-back frames need no idle cycles.
//
// Optional feature (compile-time macro SIPO_PARITY_EN):
//   When it is defined, one even-parity bit follows the WIDTH data bits
//   (FRAME = WIDTH+1). PERR is raised together with VALID when the XOR of the
//   data bits and the parity bit is 1. Q is loaded whether or not PERR is set.
//   When it is not defined, FRAME = WIDTH and PERR is tied to 0.
//
// Parameters:
//   WIDTH  data bits per word, 2..16
//
// Ports:
//   C      clock, all state changes on the rising edge
//   R      synchronous active-high reset, has priority over EN
//   D      serial data bit
//   EN     D carries a valid bit this cycle
//   Q      last completed word (registered; held between VALID pulses)
//   VALID  one-cycle pulse when Q takes a new word
//   BCNT   number of bits accepted so far in the current frame
//   PERR   parity error, only meaningful with VALID (0 whenever VALID=0)
// ----------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic [4:0]       BCNT,
    output logic             PERR
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    // BCNT value just before the edge that completes a frame.
    localparam logic [4:0] LP_LAST = 5'(FRAME - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_sh_shift;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [4:0]       r_bcnt;
    logic [4:0]       w_bcnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             w_last;

`ifdef SIPO_PARITY_EN
    logic             r_perr;
    logic             w_perr_nxt;
`endif

    // The internal shift register moves left, so after WIDTH shifts the first
    // bit sits in the MSB.
    assign w_sh_shift = {r_sh[WIDTH-2:0], D};

    // In IDLE and LOAD the count is 0, and FRAME >= 2, so this can only be
    // true while shifting.
    assign w_last = EN && (r_bcnt == LP_LAST);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_q_nxt     = r_q;
        w_bcnt_nxt  = r_bcnt;
        w_valid_nxt = 1'b0;
`ifdef SIPO_PARITY_EN
        w_perr_nxt  = 1'b0;
`endif

        case (r_state)
            // LOAD behaves like IDLE for the incoming bit: this is what lets
            // a new frame start in the same cycle VALID is high.
            S_IDLE, S_LOAD: begin
                if (EN) begin
                    w_state_nxt = S_SHIFT;
                    w_bcnt_nxt  = 5'd1;
                    // Stale contents are shifted out before the word is used.
                    w_sh_nxt    = w_sh_shift;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_LOAD;
                    w_bcnt_nxt  = 5'd0;
                    w_valid_nxt = 1'b1;
`ifdef SIPO_PARITY_EN
                    // Data is already complete in r_sh; D is the parity bit.
                    w_q_nxt     = r_sh;
                    w_perr_nxt  = (^r_sh) ^ D;
`else
                    // The final data bit is still on D; load it directly.
                    w_q_nxt     = w_sh_shift;
`endif
                end else if (EN) begin
                    w_bcnt_nxt  = r_bcnt + 5'd1;
                    w_sh_nxt    = w_sh_shift;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_bcnt_nxt  = 5'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_q     <= '0;
            r_bcnt  <= 5'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_q     <= w_q_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge C) begin
        if (R) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_nxt;
        end
    end

    assign PERR  = r_perr;
`else
    assign PERR  = 1'b0;
`endif

    assign Q     = r_q;
    assign VALID = r_valid;
    assign BCNT  = r_bcnt;

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per word, legal range 2..16.
REQ-002 SHALL have port C, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port R, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port D, input, 1 bit: serial data bit, driven by an upstream dff Q output.
REQ-005 SHALL have port EN, input, 1 bit: D is a valid bit this cycle.
REQ-006 SHALL have port Q, output, WIDTH bits: last completed word, registered.
REQ-007 SHALL have port VALID, output, 1 bit: one-cycle pulse when Q takes a new word.
REQ-008 SHALL have port BCNT, output, 5 bits: number of bits accepted in the current frame.
REQ-009 SHALL have port PERR, output, 1 bit: parity error flag, qualified by VALID.

Function
REQ-010 SHALL sample D only on rising C edges where EN=1 and R=0; EN=0 edges leave all frame state unchanged.
REQ-011 SHALL shift MSB-first: the first accepted bit of a frame lands in Q[WIDTH-1].
REQ-012 SHALL implement states IDLE (BCNT=0), SHIFT (0<BCNT<FRAME) and LOAD (one cycle, VALID=1), with FRAME = WIDTH, or WIDTH+1 when parity is compiled in.
REQ-013 SHALL increment BCNT by 1 per accepted bit; IDLE->SHIFT on the first accepted bit.
REQ-014 SHALL, on the edge accepting bit number FRAME, copy the assembled word into Q, set VALID=1 for exactly the following cycle, and return BCNT to 0 (no wrap past FRAME).
REQ-015 SHALL allow EN gaps of any length inside a frame without losing accumulated bits.
REQ-016 SHALL accept a bit of the next frame in the same cycle VALID=1 (back-to-back frames, zero idle cycles); that bit sets BCNT=1.
REQ-017 SHALL hold Q stable between VALID pulses; the partial shift register is internal and SHALL never be visible on Q.
REQ-018 SHALL drive PERR=0 whenever VALID=0.

Reset
REQ-019 SHALL, with R=1 at a rising C edge, set Q=0, VALID=0, PERR=0, BCNT=0 and state IDLE; R has priority over EN.
REQ-020 SHALL discard a partial frame when R is asserted mid-frame; the first accepted bit after R deasserts starts a new frame.
REQ-021 SHALL cancel a pending VALID pulse if R coincides with the completing edge.

Configuration
REQ-022 SHALL, when macro SIPO_PARITY_EN is defined, append one even-parity bit after the WIDTH data bits (FRAME=WIDTH+1); PERR=1 with VALID when XOR of data bits and parity bit is 1; Q is loaded regardless of PERR.
REQ-023 SHALL, without SIPO_PARITY_EN, use FRAME=WIDTH, keep port PERR, tie it to 0, and contain no parity logic.

Verification
REQ-024 SHALL cover: R=1 for 2 cycles, then EN=1 with D=1,0,1,1,0,0,1,0 on consecutive edges -> Q=8'hB2, VALID high exactly one cycle after the 8th edge, BCNT returns to 0.
REQ-025 SHALL cover: same bits as REQ-024 with EN=0 for 3 cycles after bit 4 -> Q=8'hB2, VALID delayed 3 cycles, no bits lost.
REQ-026 SHALL cover: words 8'hFF then 8'h00 on 16 consecutive EN=1 edges -> two VALID pulses 8 cycles apart, Q=8'hFF then 8'h00.
REQ-027 SHALL cover: 5 bits accepted, R=1 one edge, then 8 bits of 8'h5A -> Q=8'h5A, no VALID before the 8th new bit.
REQ-028 SHALL cover (SIPO_PARITY_EN): 8'hB2 with parity 0 -> PERR=0; 8'hB2 with parity 1 -> PERR=1 with VALID, Q=8'hB2 in both cases.
REQ-029 SHALL cover (no macro): any frame -> PERR=0 on every cycle.
